// File: rtl/serial_filterbank.sv
// Time-multiplexed FIR filterbank: NUM_CH channels share one NTAPS-deep delay line
// and one multiply-accumulate unit, with coefficients held in a writable RAM.
module serial_filterbank #(
   parameter int IN_W   = 14,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 119,
   parameter int NUM_CH = 16,
   parameter int OUT_W  = 35,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int TAP_W = $clog2(NTAPS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic [IN_W-1:0]   filter_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              coef_we,
   input  logic [CH_W-1:0]   coef_ch,
   input  logic [TAP_W-1:0]  coef_tap,
   input  logic [COEF_W-1:0] coef_data,
   output logic [OUT_W-1:0]  filter_out,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic              busy
);

   localparam int PROD_W = IN_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(NTAPS);
   localparam int DEPTH  = NUM_CH * NTAPS;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic signed [IN_W-1:0]   dl_q [NTAPS];
   logic signed [IN_W-1:0]   dl_d [NTAPS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [TAP_W-1:0]         tap_q, tap_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic [CH_W-1:0]          out_ch_q, out_ch_d;
   logic signed [OUT_W-1:0]  filter_out_q, filter_out_d;
   logic                     out_valid_q, out_valid_d;

   logic signed [COEF_W-1:0] coef_mem [DEPTH];
   logic [ADDR_W-1:0]        wr_addr, rd_addr;
   logic                     wr_ok;
   logic signed [COEF_W-1:0] coef_rd;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  sum;
   logic signed [OUT_W-1:0]  sum_sat;
   logic                     last_tap, last_ch;

   assign wr_addr = ADDR_W'(coef_ch) * ADDR_W'(NTAPS) + ADDR_W'(coef_tap);
   assign rd_addr = ADDR_W'(ch_q) * ADDR_W'(NTAPS) + ADDR_W'(tap_q);
   assign wr_ok   = coef_we && (32'(coef_ch) < 32'(NUM_CH)) && (32'(coef_tap) < 32'(NTAPS));

   // Asynchronous read: a write at this edge is seen only by later MAC cycles.
   always_ff @(posedge clock) begin
      if (clk_enable && wr_ok)
         coef_mem[wr_addr] <= coef_data;
   end

   assign coef_rd  = coef_mem[rd_addr];
   assign prod     = dl_q[tap_q] * coef_rd;
   assign sum      = acc_q + ACC_W'(prod);
   assign last_tap = (tap_q == TAP_W'(NTAPS - 1));
   assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));

   generate
      if (ACC_W > OUT_W) begin : g_sat
         logic [ACC_W-OUT_W:0] top;
         assign top     = sum[ACC_W-1:OUT_W-1];
         assign sum_sat = (&top || ~|top) ? sum[OUT_W-1:0] :
                          (sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
      end else if (ACC_W == OUT_W) begin : g_same
         assign sum_sat = sum;
      end else begin : g_ext
         assign sum_sat = {{(OUT_W-ACC_W){sum[ACC_W-1]}}, sum};
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else if (clk_enable)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = MAC;
         MAC:     if (last_tap && last_ch) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE);
      busy     = (state_q == MAC);
   end

   always_comb begin
      dl_d         = dl_q;
      acc_d        = acc_q;
      tap_d        = tap_q;
      ch_d         = ch_q;
      out_ch_d     = out_ch_q;
      filter_out_d = filter_out_q;
      out_valid_d  = 1'b0;
      if (state_q == IDLE) begin
         if (in_valid) begin
            dl_d[0] = filter_in;
            for (int k = 1; k < NTAPS; k++)
               dl_d[k] = dl_q[k-1];
            acc_d = '0;
            tap_d = '0;
            ch_d  = '0;
         end
      end else if (last_tap) begin
         filter_out_d = sum_sat;
         out_ch_d     = ch_q;
         out_valid_d  = 1'b1;
         acc_d        = '0;
         tap_d        = '0;
         if (!last_ch)
            ch_d = ch_q + 1'b1;
      end else begin
         acc_d = sum;
         tap_d = tap_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NTAPS; k++)
            dl_q[k] <= '0;
         acc_q        <= '0;
         tap_q        <= '0;
         ch_q         <= '0;
         out_ch_q     <= '0;
         filter_out_q <= '0;
         out_valid_q  <= 1'b0;
      end else if (clk_enable) begin
         dl_q         <= dl_d;
         acc_q        <= acc_d;
         tap_q        <= tap_d;
         ch_q         <= ch_d;
         out_ch_q     <= out_ch_d;
         filter_out_q <= filter_out_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign filter_out = filter_out_q;
   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;

endmodule
